// File: rtl/axi4_mem_arbiter.sv
// Arbitrates one AXI4 master port between the IFU (read-only) and the LSU (read/write),
// round-robin, one whole transaction at a time. Optional counters: AXI4_ARB_PERF_CNT_EN.
module axi4_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read channels
  input  logic                s0_arvalid_i,
  output logic                s0_arready_o,
  input  logic [ADDR_W-1:0]   s0_araddr_i,
  input  logic [ID_W-1:0]     s0_arid_i,
  input  logic [7:0]          s0_arlen_i,
  input  logic [2:0]          s0_arsize_i,
  input  logic [1:0]          s0_arburst_i,
  output logic                s0_rvalid_o,
  input  logic                s0_rready_i,
  output logic [DATA_W-1:0]   s0_rdata_o,
  output logic [1:0]          s0_rresp_o,
  output logic [ID_W-1:0]     s0_rid_o,
  output logic                s0_rlast_o,
  // LSU read channels
  input  logic                s1_arvalid_i,
  output logic                s1_arready_o,
  input  logic [ADDR_W-1:0]   s1_araddr_i,
  input  logic [ID_W-1:0]     s1_arid_i,
  input  logic [7:0]          s1_arlen_i,
  input  logic [2:0]          s1_arsize_i,
  input  logic [1:0]          s1_arburst_i,
  output logic                s1_rvalid_o,
  input  logic                s1_rready_i,
  output logic [DATA_W-1:0]   s1_rdata_o,
  output logic [1:0]          s1_rresp_o,
  output logic [ID_W-1:0]     s1_rid_o,
  output logic                s1_rlast_o,
  // LSU write channels
  input  logic                s1_awvalid_i,
  output logic                s1_awready_o,
  input  logic [ADDR_W-1:0]   s1_awaddr_i,
  input  logic [ID_W-1:0]     s1_awid_i,
  input  logic [7:0]          s1_awlen_i,
  input  logic [2:0]          s1_awsize_i,
  input  logic [1:0]          s1_awburst_i,
  input  logic                s1_wvalid_i,
  output logic                s1_wready_o,
  input  logic [DATA_W-1:0]   s1_wdata_i,
  input  logic [DATA_W/8-1:0] s1_wstrb_i,
  input  logic                s1_wlast_i,
  output logic                s1_bvalid_o,
  input  logic                s1_bready_i,
  output logic [1:0]          s1_bresp_o,
  output logic [ID_W-1:0]     s1_bid_o,
  // Downstream master port
  output logic                m_awvalid_o,
  input  logic                m_awready_i,
  output logic [ADDR_W-1:0]   m_awaddr_o,
  output logic [ID_W-1:0]     m_awid_o,
  output logic [7:0]          m_awlen_o,
  output logic [2:0]          m_awsize_o,
  output logic [1:0]          m_awburst_o,
  output logic                m_wvalid_o,
  input  logic                m_wready_i,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  output logic                m_wlast_o,
  input  logic                m_bvalid_i,
  output logic                m_bready_o,
  input  logic [1:0]          m_bresp_i,
  input  logic [ID_W-1:0]     m_bid_i,
  output logic                m_arvalid_o,
  input  logic                m_arready_i,
  output logic [ADDR_W-1:0]   m_araddr_o,
  output logic [ID_W-1:0]     m_arid_o,
  output logic [7:0]          m_arlen_o,
  output logic [2:0]          m_arsize_o,
  output logic [1:0]          m_arburst_o,
  input  logic                m_rvalid_i,
  output logic                m_rready_o,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic [1:0]          m_rresp_i,
  input  logic [ID_W-1:0]     m_rid_i,
  input  logic                m_rlast_i
`ifdef AXI4_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_ifu_grants_o,
  output logic [31:0]         perf_lsu_grants_o,
  output logic [31:0]         perf_wait_cycles_o
`endif
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   grant_ifu, grant_lsu;
  logic   req0, req1;

  assign req0 = s0_arvalid_i;
  assign req1 = s1_arvalid_i | s1_awvalid_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ar_done_d    = ar_done_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    grant_ifu    = 1'b0;
    grant_lsu    = 1'b0;

    s0_arready_o = 1'b0;
    s0_rvalid_o  = 1'b0;
    s0_rdata_o   = '0;
    s0_rresp_o   = '0;
    s0_rid_o     = '0;
    s0_rlast_o   = 1'b0;
    s1_arready_o = 1'b0;
    s1_rvalid_o  = 1'b0;
    s1_rdata_o   = '0;
    s1_rresp_o   = '0;
    s1_rid_o     = '0;
    s1_rlast_o   = 1'b0;
    s1_awready_o = 1'b0;
    s1_wready_o  = 1'b0;
    s1_bvalid_o  = 1'b0;
    s1_bresp_o   = '0;
    s1_bid_o     = '0;
    m_awvalid_o  = 1'b0;
    m_awaddr_o   = '0;
    m_awid_o     = '0;
    m_awlen_o    = '0;
    m_awsize_o   = '0;
    m_awburst_o  = '0;
    m_wvalid_o   = 1'b0;
    m_wdata_o    = '0;
    m_wstrb_o    = '0;
    m_wlast_o    = 1'b0;
    m_bready_o   = 1'b0;
    m_arvalid_o  = 1'b0;
    m_araddr_o   = '0;
    m_arid_o     = '0;
    m_arlen_o    = '0;
    m_arsize_o   = '0;
    m_arburst_o  = '0;
    m_rready_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time is served.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = IFU_RD;
          last_grant_d = 1'b0;
          grant_ifu    = 1'b1;
        end else if (req1) begin
          state_d      = s1_awvalid_i ? LSU_WR : LSU_RD;
          last_grant_d = 1'b1;
          grant_lsu    = 1'b1;
        end
      end
      IFU_RD: begin
        m_araddr_o   = s0_araddr_i;
        m_arid_o     = s0_arid_i;
        m_arlen_o    = s0_arlen_i;
        m_arsize_o   = s0_arsize_i;
        m_arburst_o  = s0_arburst_i;
        m_arvalid_o  = s0_arvalid_i & ~ar_done_q;
        s0_arready_o = m_arready_i & ~ar_done_q;
        if (m_arvalid_o && m_arready_i) ar_done_d = 1'b1;
        s0_rvalid_o  = m_rvalid_i;
        s0_rdata_o   = m_rdata_i;
        s0_rresp_o   = m_rresp_i;
        s0_rid_o     = m_rid_i;
        s0_rlast_o   = m_rlast_i;
        m_rready_o   = s0_rready_i;
        if (m_rvalid_i && s0_rready_i && m_rlast_i) state_d = IDLE;
      end
      LSU_RD: begin
        m_araddr_o   = s1_araddr_i;
        m_arid_o     = s1_arid_i;
        m_arlen_o    = s1_arlen_i;
        m_arsize_o   = s1_arsize_i;
        m_arburst_o  = s1_arburst_i;
        m_arvalid_o  = s1_arvalid_i & ~ar_done_q;
        s1_arready_o = m_arready_i & ~ar_done_q;
        if (m_arvalid_o && m_arready_i) ar_done_d = 1'b1;
        s1_rvalid_o  = m_rvalid_i;
        s1_rdata_o   = m_rdata_i;
        s1_rresp_o   = m_rresp_i;
        s1_rid_o     = m_rid_i;
        s1_rlast_o   = m_rlast_i;
        m_rready_o   = s1_rready_i;
        if (m_rvalid_i && s1_rready_i && m_rlast_i) state_d = IDLE;
      end
      LSU_WR: begin
        // AW and W complete independently; each is masked once its handshake is done.
        m_awaddr_o   = s1_awaddr_i;
        m_awid_o     = s1_awid_i;
        m_awlen_o    = s1_awlen_i;
        m_awsize_o   = s1_awsize_i;
        m_awburst_o  = s1_awburst_i;
        m_awvalid_o  = s1_awvalid_i & ~aw_done_q;
        s1_awready_o = m_awready_i & ~aw_done_q;
        if (m_awvalid_o && m_awready_i) aw_done_d = 1'b1;
        m_wdata_o    = s1_wdata_i;
        m_wstrb_o    = s1_wstrb_i;
        m_wlast_o    = s1_wlast_i;
        m_wvalid_o   = s1_wvalid_i & ~w_done_q;
        s1_wready_o  = m_wready_i & ~w_done_q;
        if (m_wvalid_o && m_wready_i) w_done_d = 1'b1;
        s1_bvalid_o  = m_bvalid_i;
        s1_bresp_o   = m_bresp_i;
        s1_bid_o     = m_bid_i;
        m_bready_o   = s1_bready_i;
        if (m_bvalid_i && s1_bready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      ar_done_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

`ifdef AXI4_ARB_PERF_CNT_EN
  logic [31:0] ifu_cnt_q, lsu_cnt_q, wait_cnt_q;
  logic        wait_inc;

  assign wait_inc = ((state_q == IDLE) && req0 && req1) ||
                    ((state_q == IFU_RD) && req1) ||
                    (((state_q == LSU_RD) || (state_q == LSU_WR)) && req0);

  always_ff @(posedge clock) begin
    if (reset) begin
      ifu_cnt_q  <= '0;
      lsu_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (grant_ifu) ifu_cnt_q  <= ifu_cnt_q + 32'd1;
      if (grant_lsu) lsu_cnt_q  <= lsu_cnt_q + 32'd1;
      if (wait_inc)  wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign perf_ifu_grants_o  = ifu_cnt_q;
  assign perf_lsu_grants_o  = lsu_cnt_q;
  assign perf_wait_cycles_o = wait_cnt_q;
`endif

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter: table-driven single-beat reads plus
// hand-written contention, write-ordering, burst and mid-transaction reset sequences.
module tb_axi4_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [AW-1:0] s0_araddr;
  logic [IW-1:0] s0_arid, s0_rid;
  logic [7:0]    s0_arlen;
  logic [2:0]    s0_arsize;
  logic [1:0]    s0_arburst, s0_rresp;
  logic [DW-1:0] s0_rdata;
  logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [AW-1:0] s1_araddr;
  logic [IW-1:0] s1_arid, s1_rid;
  logic [7:0]    s1_arlen;
  logic [2:0]    s1_arsize;
  logic [1:0]    s1_arburst, s1_rresp;
  logic [DW-1:0] s1_rdata;
  logic          s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
  logic [AW-1:0] s1_awaddr;
  logic [IW-1:0] s1_awid, s1_bid;
  logic [7:0]    s1_awlen;
  logic [2:0]    s1_awsize;
  logic [1:0]    s1_awburst, s1_bresp;
  logic [DW-1:0] s1_wdata;
  logic [DW/8-1:0] s1_wstrb;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [AW-1:0] m_awaddr;
  logic [IW-1:0] m_awid, m_bid;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst, m_bresp;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0] m_araddr;
  logic [IW-1:0] m_arid, m_rid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst, m_rresp;
  logic [DW-1:0] m_rdata;
`ifdef AXI4_ARB_PERF_CNT_EN
  logic [31:0]   perf_ifu, perf_lsu, perf_wait;
`endif

  axi4_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr),
    .s0_arid_i(s0_arid), .s0_arlen_i(s0_arlen), .s0_arsize_i(s0_arsize), .s0_arburst_i(s0_arburst),
    .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rdata_o(s0_rdata), .s0_rresp_o(s0_rresp),
    .s0_rid_o(s0_rid), .s0_rlast_o(s0_rlast),
    .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr),
    .s1_arid_i(s1_arid), .s1_arlen_i(s1_arlen), .s1_arsize_i(s1_arsize), .s1_arburst_i(s1_arburst),
    .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rdata_o(s1_rdata), .s1_rresp_o(s1_rresp),
    .s1_rid_o(s1_rid), .s1_rlast_o(s1_rlast),
    .s1_awvalid_i(s1_awvalid), .s1_awready_o(s1_awready), .s1_awaddr_i(s1_awaddr),
    .s1_awid_i(s1_awid), .s1_awlen_i(s1_awlen), .s1_awsize_i(s1_awsize), .s1_awburst_i(s1_awburst),
    .s1_wvalid_i(s1_wvalid), .s1_wready_o(s1_wready), .s1_wdata_i(s1_wdata), .s1_wstrb_i(s1_wstrb),
    .s1_wlast_i(s1_wlast), .s1_bvalid_o(s1_bvalid), .s1_bready_i(s1_bready), .s1_bresp_o(s1_bresp),
    .s1_bid_o(s1_bid),
    .m_awvalid_o(m_awvalid), .m_awready_i(m_awready), .m_awaddr_o(m_awaddr), .m_awid_o(m_awid),
    .m_awlen_o(m_awlen), .m_awsize_o(m_awsize), .m_awburst_o(m_awburst),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_wlast_o(m_wlast), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready), .m_bresp_i(m_bresp),
    .m_bid_i(m_bid),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr), .m_arid_o(m_arid),
    .m_arlen_o(m_arlen), .m_arsize_o(m_arsize), .m_arburst_o(m_arburst),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rresp_i(m_rresp),
    .m_rid_i(m_rid), .m_rlast_i(m_rlast)
`ifdef AXI4_ARB_PERF_CNT_EN
    , .perf_ifu_grants_o(perf_ifu), .perf_lsu_grants_o(perf_lsu), .perf_wait_cycles_o(perf_wait)
`endif
  );

  int total = 0;
  int bad = 0;
  int aw_hs = 0;
  int w_hs = 0;

  always @(posedge clock) begin
    if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
    if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit          req;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] exp_araddr;
    logic [3:0]  exp_rid;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } rd_vec_t;

  rd_vec_t vecs[5];

  task automatic clear_inputs();
    s0_arvalid = 0; s0_araddr = '0; s0_arid = '0; s0_arlen = '0; s0_arsize = 3'd2; s0_arburst = 2'd1;
    s0_rready = 0;
    s1_arvalid = 0; s1_araddr = '0; s1_arid = '0; s1_arlen = '0; s1_arsize = 3'd2; s1_arburst = 2'd1;
    s1_rready = 0;
    s1_awvalid = 0; s1_awaddr = '0; s1_awid = '0; s1_awlen = '0; s1_awsize = 3'd2; s1_awburst = 2'd1;
    s1_wvalid = 0; s1_wdata = '0; s1_wstrb = '0; s1_wlast = 0; s1_bready = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0; m_bid = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = 0;
  endtask

  // One complete single-beat read, requester chosen by v.req
  task automatic do_read(input rd_vec_t v);
    if (v.req == 1'b0) begin
      s0_arvalid = 1; s0_araddr = v.addr; s0_arid = v.id; s0_arlen = 0;
    end else begin
      s1_arvalid = 1; s1_araddr = v.addr; s1_arid = v.id; s1_arlen = 0;
    end
    #1 chk("rd_no_fwd_same_cycle", m_arvalid, 0);
    tick();
    chk("rd_arvalid_next_cycle", m_arvalid, 1);
    chk("rd_araddr", m_araddr, v.exp_araddr);
    chk("rd_arid", m_arid, v.exp_rid);
    m_arready = 1;
    #1 chk("rd_owner_arready", v.req ? s1_arready : s0_arready, 1);
    chk("rd_other_arready", v.req ? s0_arready : s1_arready, 0);
    tick();
    s0_arvalid = 0; s1_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = v.data; m_rid = v.id; m_rresp = v.resp; m_rlast = 1;
    s0_rready = 1; s1_rready = 1;
    #1 chk("rd_owner_rvalid", v.req ? s1_rvalid : s0_rvalid, 1);
    chk("rd_owner_rdata", v.req ? s1_rdata : s0_rdata, v.exp_rdata);
    chk("rd_owner_rid", v.req ? s1_rid : s0_rid, v.exp_rid);
    chk("rd_owner_rresp", v.req ? s1_rresp : s0_rresp, v.exp_rresp);
    chk("rd_other_rvalid", v.req ? s0_rvalid : s1_rvalid, 0);
    chk("rd_m_rready", m_rready, 1);
    tick();
    // Stray R beat in IDLE must not be acknowledged
    #1 chk("rd_idle_rready", m_rready, 0);
    chk("rd_idle_s0_rvalid", s0_rvalid, 0);
    chk("rd_idle_s1_rvalid", s1_rvalid, 0);
    m_rvalid = 0; m_rlast = 0; s0_rready = 0; s1_rready = 0;
    $display("read req=%0d addr=%h data=%h done", v.req, v.addr, v.data);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data);
    s1_awvalid = 1; s1_awaddr = addr; s1_awid = id;
    s1_wvalid = 1; s1_wdata = data; s1_wstrb = 4'hF; s1_wlast = 1;
    tick();
    chk("wr_awvalid", m_awvalid, 1);
    chk("wr_awaddr", m_awaddr, addr);
    chk("wr_wvalid", m_wvalid, 1);
    chk("wr_wdata", m_wdata, data);
    m_awready = 1; m_wready = 1;
    tick();
    s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bid = id; m_bresp = 2'd0; s1_bready = 1;
    #1 chk("wr_bvalid", s1_bvalid, 1);
    chk("wr_bid", s1_bid, id);
    tick();
    m_bvalid = 0; s1_bready = 0;
    $display("write addr=%h data=%h done", addr, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0;
    logic [31:0] exp_addr;

    vecs[0] = '{1'b0, 32'h3000_0000, 4'h1, 32'hDEAD_BEEF, 2'd0, 32'h3000_0000, 4'h1, 32'hDEAD_BEEF, 2'd0};
    vecs[1] = '{1'b1, 32'h4000_0010, 4'h7, 32'h1234_5678, 2'd0, 32'h4000_0010, 4'h7, 32'h1234_5678, 2'd0};
    vecs[2] = '{1'b0, 32'h3000_0044, 4'hA, 32'hCAFE_F00D, 2'd2, 32'h3000_0044, 4'hA, 32'hCAFE_F00D, 2'd2};
    vecs[3] = '{1'b1, 32'h4000_0FFC, 4'hF, 32'h0000_0001, 2'd3, 32'h4000_0FFC, 4'hF, 32'h0000_0001, 2'd3};
    vecs[4] = '{1'b0, 32'h3000_0008, 4'h2, 32'hA5A5_5A5A, 2'd0, 32'h3000_0008, 4'h2, 32'hA5A5_5A5A, 2'd0};

    clear_inputs();
    reset = 1;
    tick();
    // Requests and responses during reset see nothing
    s0_arvalid = 1; s1_awvalid = 1; s1_wvalid = 1; m_rvalid = 1; m_bvalid = 1;
    tick();
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid", m_wvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_m_bready", m_bready, 0);
    chk("rst_s0_rvalid", s0_rvalid, 0);
    chk("rst_s1_bvalid", s1_bvalid, 0);
    chk("rst_m_araddr", m_araddr, 0);
    clear_inputs();
    reset = 0;
    tick();
    $display("reset done");

    // Four back-to-back contentions: IFU, LSU, IFU, LSU
    for (int i = 0; i < 4; i++) begin
      s0_arvalid = 1; s0_araddr = 32'h3000_1000; s0_arid = 4'h3;
      s1_arvalid = 1; s1_araddr = 32'h4000_2000; s1_arid = 4'h9;
      exp_addr = (i % 2 == 0) ? 32'h3000_1000 : 32'h4000_2000;
      tick();
      chk("cont_araddr", m_araddr, exp_addr);
      m_arready = 1;
      #1 chk("cont_s0_arready", s0_arready, (i % 2 == 0) ? 1 : 0);
      chk("cont_s1_arready", s1_arready, (i % 2 == 0) ? 0 : 1);
      tick();
      m_arready = 0;
      if (i % 2 == 0) s0_arvalid = 0; else s1_arvalid = 0;
      m_rvalid = 1; m_rlast = 1; m_rdata = 32'h100 + i; s0_rready = 1; s1_rready = 1;
      #1 chk("cont_owner_rdata", (i % 2 == 0) ? s0_rdata : s1_rdata, 32'h100 + i);
      chk("cont_other_rvalid", (i % 2 == 0) ? s1_rvalid : s0_rvalid, 0);
      tick();
      m_rvalid = 0; m_rlast = 0; s0_rready = 0; s1_rready = 0;
      $display("contention %0d granted addr=%h", i, exp_addr);
    end
    s0_arvalid = 0; s1_arvalid = 0;
    tick();

    for (int i = 0; i < 5; i++) do_read(vecs[i]);

    // Write with W handshake two cycles ahead of AW
    aw0 = aw_hs; w0 = w_hs;
    s1_awvalid = 1; s1_awaddr = 32'h5000_0020; s1_awid = 4'h6;
    s1_wvalid = 1; s1_wdata = 32'h0BAD_F00D; s1_wstrb = 4'hF; s1_wlast = 1;
    tick();
    chk("wo_awvalid", m_awvalid, 1);
    chk("wo_awid", m_awid, 4'h6);
    chk("wo_arvalid_held", m_arvalid, 0);
    m_wready = 1;
    #1 chk("wo_s1_wready", s1_wready, 1);
    tick();
    chk("wo_wvalid_masked", m_wvalid, 0);
    chk("wo_s1_wready_masked", s1_wready, 0);
    m_rvalid = 1;
    #1 chk("wo_r_not_acked", m_rready, 0);
    m_rvalid = 0;
    tick();
    m_awready = 1;
    #1 chk("wo_s1_awready", s1_awready, 1);
    tick();
    chk("wo_awvalid_masked", m_awvalid, 0);
    s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bid = 4'h6; m_bresp = 2'd1; s1_bready = 1;
    #1 chk("wo_bvalid", s1_bvalid, 1);
    chk("wo_bid", s1_bid, 4'h6);
    chk("wo_bresp", s1_bresp, 2'd1);
    chk("wo_m_bready", m_bready, 1);
    tick();
    m_bvalid = 0; s1_bready = 0;
    chk("wo_one_aw", aw_hs - aw0, 1);
    chk("wo_one_w", w_hs - w0, 1);
    $display("write W-before-AW done");

    // IFU burst of 4 beats with an LSU read waiting behind it
    s0_arvalid = 1; s0_araddr = 32'h3000_0100; s0_arid = 4'h4; s0_arlen = 8'd3;
    tick();
    s1_arvalid = 1; s1_araddr = 32'h4000_0040; s1_arid = 4'h5;
    chk("bu_araddr", m_araddr, 32'h3000_0100);
    chk("bu_arlen", m_arlen, 8'd3);
    m_arready = 1;
    tick();
    s0_arvalid = 0; m_arready = 0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rdata = 32'h1000 + b; m_rid = 4'h4; m_rlast = (b == 3); s0_rready = 1;
      #1 chk("bu_s0_rdata", s0_rdata, 32'h1000 + b);
      chk("bu_s1_rvalid", s1_rvalid, 0);
      chk("bu_lsu_not_fwd", m_arvalid, 0);
      tick();
    end
    m_rvalid = 0; m_rlast = 0; s0_rready = 0;
    #1 chk("bu_idle_after_rlast", m_arvalid, 0);
    tick();
    chk("bu_lsu_granted", m_arvalid, 1);
    chk("bu_lsu_araddr", m_araddr, 32'h4000_0040);
    $display("burst done, LSU granted");

    // Reset in LSU_RD after the AR handshake
    m_arready = 1;
    tick();
    m_arready = 0;
    chk("rs_ar_masked", m_arvalid, 0);
    reset = 1; m_rvalid = 1; m_rlast = 1; s1_rready = 1;
    tick();
    chk("rs_arvalid", m_arvalid, 0);
    chk("rs_s1_arready", s1_arready, 0);
    chk("rs_rready", m_rready, 0);
    chk("rs_s1_rvalid", s1_rvalid, 0);
    reset = 0; m_rvalid = 0; m_rlast = 0;
    tick();
    chk("rs_regrant_arvalid", m_arvalid, 1);
    m_arready = 1;
    tick();
    s1_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rlast = 1;
    tick();
    m_rvalid = 0; m_rlast = 0; s1_rready = 0;
    $display("reset mid-read done");

    // Fresh reset, then 3 IFU reads and 2 LSU writes
    reset = 1;
    tick();
    reset = 0;
    tick();
    do_read(vecs[0]);
    do_read(vecs[2]);
    do_read(vecs[4]);
    do_write(32'h5000_0000, 4'h1, 32'h1111_1111);
    do_write(32'h5000_0004, 4'h2, 32'h2222_2222);
`ifdef AXI4_ARB_PERF_CNT_EN
    chk("perf_ifu", perf_ifu, 32'd3);
    chk("perf_lsu", perf_lsu, 32'd2);
    chk("perf_wait", perf_wait, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
